jacob_to_affine_xy: RTL and testbench
=====================================

// Module: jacob_to_affine_xy
// PURPOSE
// - Converts a Jacobian point (X3,Y3,Z3) over GF(p) to affine: x = X3/Z3^2 mod p, y = Y3/Z3^3 mod p.
// - Parametrised successor of the x-only converter: adds y output, WIDTH parameter, start/busy/done handshake, Z3=0 detection.
// - Sits at the output of the ECC point-multiply core, feeding affine coordinates to the result register / host interface.
// PARAMETERS
// - WIDTH   256  operand width in bits (p, X3, Y3, Z3, x, y)
// - WITH_Y  1    1: compute x and y; 0: x only (y driven 0, Y-multiply states skipped)
// PORTS
// - clk     in   1      rising-edge clock
// - rst     in   1      synchronous, active-high reset
// - start   in   1      request; sampled only in IDLE
// - x3      in   WIDTH  Jacobian X, precondition x3 < p
// - y3      in   WIDTH  Jacobian Y, precondition y3 < p
// - z3      in   WIDTH  Jacobian Z, precondition z3 < p
// - p       in   WIDTH  odd prime modulus, 3 <= p < 2^WIDTH
// - busy    out  1      high from cycle after accepted start until done
// - done    out  1      one-cycle pulse, results valid from this cycle
// - inf     out  1      Z3 was 0 (point at infinity); valid with done
// - x       out  WIDTH  affine x, held until next accepted start
// - y       out  WIDTH  affine y, held until next accepted start
// BEHAVIOUR
// - Reset: busy=0, done=0, inf=0, x=0, y=0, FSM=IDLE; reset mid-operation aborts, no done pulse.
// - IDLE: start=1 latches x3,y3,z3,p; next cycle busy=1. start while busy ignored; inputs may change after acceptance.
// - Z3==0 at acceptance: go directly to DONE; inf=1, x=0, y=0 (latency 2 cycles start->done).
// - INV: zi = Z3^-1 mod p, binary extended Euclid (u,v,x1,x2), one step/cycle, <= 2*WIDTH cycles.
//   Halving of x1/x2: if odd add p first, WIDTH+1-bit intermediate, shift right; subtraction wraps by adding p.
// - SQR: zi2 = zi*zi mod p. MULX: x = X3*zi2 mod p.
// - WITH_Y=1: MULZ3: zi3 = zi2*zi mod p; MULY: y = Y3*zi3 mod p. WITH_Y=0: skip to DONE.
// - Each multiply via mod_mul_serial: MSB-first shift-add, one bit/cycle, two conditional -p per bit,
//   WIDTH+2 bits internally; fixed WIDTH+1 cycles start->done.
// - DONE: done=1 for one cycle, busy=0 same cycle, FSM -> IDLE; start in the DONE cycle is not accepted.
// - Latency bound: <= 2*WIDTH + (2+2*WITH_Y)*(WIDTH+3) + 3 cycles; exact value data dependent (INV only).
// - States: IDLE -> (z3==0 ? DONE : INV) -> SQR -> MULX -> [MULZ3 -> MULY] -> DONE -> IDLE.
// - All results fully reduced: 0 <= x,y < p. Z3=1 gives x=X3, y=Y3.
// - Behaviour for inputs violating preconditions (>= p, even p) is undefined, but FSM must still reach DONE.
// STRUCTURE
// - Package ecc_pkg: localparam state encoding (IDLE,INV,SQR,MULX,MULZ3,MULY,DONE), default WIDTH.
// - Sub-module mod_mul_serial #(WIDTH): clk, rst, start, a, b, p -> r, done; one instance, time-shared by
//   SQR/MULX/MULZ3/MULY via operand muxes. Inversion datapath stays inline in this module.
// TESTING
// - p=29, X3=9, Y3=5, Z3=27, start -> zi=14, done with x=24, y=3, inf=0.
// - p=29, X3=9, Y3=5, Z3=1 -> x=9, y=5; Z3=0 -> done 2 cycles after start, inf=1, x=0, y=0.
// - WITH_Y=0, p=29, X3=9, Z3=27 -> x=24, y=0; latency bound shrinks accordingly.
// - start pulsed again while busy -> ignored, single done, results for first operands.
// - rst asserted mid-INV -> next cycle busy=0, x=y=0, no done; fresh start then completes correctly.
// - WIDTH=256, p=2^255-19, 1000 random X3,Y3,Z3<p -> match software model; done within latency bound.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared state encoding and defaults for the Jacobian-to-affine converter
package ecc_pkg;

  localparam int DEFAULT_WIDTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INV   = 3'd1,
    ST_SQR   = 3'd2,
    ST_MULX  = 3'd3,
    ST_MULZ3 = 3'd4,
    ST_MULY  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - bit-serial MSB-first modular multiplier r = a*b mod p
module mod_mul_serial #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] r,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH+1:0] acc;
  logic [CW-1:0]    cnt;
  logic             active;

  logic [WIDTH+1:0] pe;
  logic [WIDTH+1:0] s0;
  logic [WIDTH+1:0] s1;
  logic [WIDTH+1:0] s2;

  // One shift-add step: 2*acc + bit*b is below 3p, so two conditional -p fully reduce it
  always_comb begin
    pe = {2'b00, p_q};
    s0 = {acc[WIDTH:0], 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    s1 = (s0 >= pe) ? (s0 - pe) : s0;
    s2 = (s1 >= pe) ? (s1 - pe) : s1;
  end

  // Operand capture, WIDTH processing cycles (a shifted so its MSB is the live bit), then done
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        a_q    <= a;
        b_q    <= b;
        p_q    <= p;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
        active <= 1'b1;
      end else if (active) begin
        if (cnt != '0) begin
          acc <= s2;
          a_q <= a_q << 1;
          cnt <= cnt - CW'(1);
        end else begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  assign r = acc[WIDTH-1:0];

endmodule

// File: rtl/jacob_to_affine_xy.sv
// rtl/jacob_to_affine_xy.sv - Jacobian (X3,Y3,Z3) to affine (x,y) converter over GF(p)
module jacob_to_affine_xy
  import ecc_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit WITH_Y = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] y3,
  input  logic [WIDTH-1:0] z3,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             inf,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  localparam int ICW = $clog2(2 * WIDTH) + 1;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] x3_q;
  logic [WIDTH-1:0] y3_q;
  logic [WIDTH-1:0] p_q;
  logic             zero_q;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [ICW-1:0]   inv_cnt;
  logic [WIDTH-1:0] zi;
  logic [WIDTH-1:0] zi2;
  logic             inv_done;

  logic             mul_issued;
  logic             mul_start;
  logic             mul_done;
  logic             mul_state;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_r;

  // (a/2) mod p for odd p: make a even by adding p, keep the carry, then shift
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH:0] t;
    t = a[0] ? ({1'b0, a} + {1'b0, m}) : {1'b0, a};
    return t[WIDTH:1];
  endfunction

  // (a-b) mod p; a negative difference wraps back into range by adding p
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] t;
    t = {1'b0, a} - {1'b0, b};
    if (a < b) t = t + {1'b0, m};
    return t[WIDTH-1:0];
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic, handshake outputs and time-shared multiplier operand muxes
  always_comb begin
    next_state = state;
    mul_a      = zi;
    mul_b      = zi;
    mul_state  = 1'b0;
    inv_done   = (u == WIDTH'(1)) || (v == WIDTH'(1)) || (inv_cnt == ICW'(2 * WIDTH - 1));
    case (state)
      ST_IDLE:  if (start) next_state = ST_INV;
      ST_INV: begin
        if (zero_q)        next_state = ST_DONE;
        else if (inv_done) next_state = ST_SQR;
      end
      ST_SQR: begin
        mul_state = 1'b1;
        if (mul_done) next_state = ST_MULX;
      end
      ST_MULX: begin
        mul_state = 1'b1;
        mul_a     = x3_q;
        mul_b     = zi2;
        if (mul_done) next_state = WITH_Y ? ST_MULZ3 : ST_DONE;
      end
      ST_MULZ3: begin
        mul_state = 1'b1;
        mul_a     = zi2;
        if (mul_done) next_state = ST_MULY;
      end
      ST_MULY: begin
        mul_state = 1'b1;
        mul_a     = y3_q;
        if (mul_done) next_state = ST_DONE;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
    mul_start = mul_state && !mul_issued;
    busy      = (state != ST_IDLE) && (state != ST_DONE);
    done      = (state == ST_DONE);
  end

  // Operand capture, one binary-Euclid step per INV cycle, multiply result steering
  always_ff @(posedge clk) begin
    if (rst) begin
      x3_q       <= '0;
      y3_q       <= '0;
      p_q        <= '0;
      zero_q     <= 1'b0;
      u          <= '0;
      v          <= '0;
      x1         <= '0;
      x2         <= '0;
      inv_cnt    <= '0;
      zi         <= '0;
      zi2        <= '0;
      mul_issued <= 1'b0;
      x          <= '0;
      y          <= '0;
      inf        <= 1'b0;
    end else begin
      if (mul_done)       mul_issued <= 1'b0;
      else if (mul_start) mul_issued <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            x3_q    <= x3;
            y3_q    <= y3;
            p_q     <= p;
            zero_q  <= (z3 == '0);
            u       <= z3;
            v       <= p;
            x1      <= WIDTH'(1);
            x2      <= '0;
            inv_cnt <= '0;
            x       <= '0;
            y       <= '0;
            inf     <= 1'b0;
          end
        end
        ST_INV: begin
          if (zero_q) begin
            inf <= 1'b1;
          end else if (inv_done) begin
            zi <= (u == WIDTH'(1)) ? x1 : x2;
          end else begin
            // x1*z == u and x2*z == v (mod p) hold throughout; odd-odd steps subtract and halve at once
            inv_cnt <= inv_cnt + ICW'(1);
            if (!u[0]) begin
              u  <= u >> 1;
              x1 <= half_mod(x1, p_q);
            end else if (!v[0]) begin
              v  <= v >> 1;
              x2 <= half_mod(x2, p_q);
            end else if (u >= v) begin
              u  <= (u - v) >> 1;
              x1 <= half_mod(sub_mod(x1, x2, p_q), p_q);
            end else begin
              v  <= (v - u) >> 1;
              x2 <= half_mod(sub_mod(x2, x1, p_q), p_q);
            end
          end
        end
        ST_SQR:   if (mul_done) zi2 <= mul_r;
        ST_MULX:  if (mul_done) x   <= mul_r;
        ST_MULZ3: if (mul_done) zi  <= mul_r;
        ST_MULY:  if (mul_done) y   <= mul_r;
        default: ;
      endcase
    end
  end

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .p     (p_q),
    .r     (mul_r),
    .done  (mul_done)
  );

endmodule

// File: tb/tb_jacob_to_affine_xy.sv
// tb/tb_jacob_to_affine_xy.sv - directed and model-checked bench for jacob_to_affine_xy
module tb_jacob_to_affine_xy;

  localparam int W       = 8;
  localparam int LAT_XY  = 2 * W + 4 * (W + 3) + 3;
  localparam int LAT_X   = 2 * W + 2 * (W + 3) + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [W-1:0] x3 = '0;
  logic [W-1:0] y3 = '0;
  logic [W-1:0] z3 = '0;
  logic [W-1:0] p  = '0;
  logic         busy_a, done_a, inf_a, busy_b, done_b, inf_b;
  logic [W-1:0] xa, ya, xb, yb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] p, x3, y3, z3, ex, ey;
    logic         einf;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  jacob_to_affine_xy #(.WIDTH(W), .WITH_Y(1'b1)) dut_xy (
    .clk(clk), .rst(rst), .start(start_a), .x3(x3), .y3(y3), .z3(z3), .p(p),
    .busy(busy_a), .done(done_a), .inf(inf_a), .x(xa), .y(ya)
  );

  jacob_to_affine_xy #(.WIDTH(W), .WITH_Y(1'b0)) dut_x (
    .clk(clk), .rst(rst), .start(start_b), .x3(x3), .y3(y3), .z3(z3), .p(p),
    .busy(busy_b), .done(done_b), .inf(inf_b), .x(xb), .y(yb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands with start for one cycle, then scramble the inputs; returns at cycle 1
  task automatic launch(input int sel, input logic [W-1:0] pp, input logic [W-1:0] xx,
                        input logic [W-1:0] yy, input logic [W-1:0] zz);
    @(negedge clk);
    p = pp; x3 = xx; y3 = yy; z3 = zz;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    x3 = W'($urandom); y3 = W'($urandom); z3 = W'($urandom);
  endtask

  task automatic wait_done(input int sel, input int limit, output int lat, output bit ok);
    lat = 1;
    ok  = 1'b0;
    while (lat <= limit) begin
      if ((sel == 0 && done_a) || (sel == 1 && done_b)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic int inv_bf(input int a, input int m);
    for (int i = 1; i < m; i++) if ((a * i) % m == 1) return i;
    return 0;
  endfunction

  initial begin
    int  lat;
    bit  ok;
    int  pulses;
    int  primes[5];
    int  rp, rx, ry, rz, zi, ex, ey;

    tbl[0] = '{p:29,  x3:9,   y3:5,   z3:27,  ex:24,  ey:3, einf:0};
    tbl[1] = '{p:29,  x3:9,   y3:5,   z3:1,   ex:9,   ey:5, einf:0};
    tbl[2] = '{p:13,  x3:3,   y3:4,   z3:2,   ex:4,   ey:7, einf:0};
    tbl[3] = '{p:251, x3:0,   y3:0,   z3:5,   ex:0,   ey:0, einf:0};
    tbl[4] = '{p:251, x3:250, y3:250, z3:250, ex:250, ey:1, einf:0};
    tbl[5] = '{p:3,   x3:2,   y3:1,   z3:2,   ex:2,   ey:2, einf:0};
    tbl[6] = '{p:29,  x3:28,  y3:28,  z3:28,  ex:28,  ey:1, einf:0};
    tbl[7] = '{p:29,  x3:9,   y3:5,   z3:0,   ex:0,   ey:0, einf:1};
    primes = '{3, 13, 29, 233, 251};

    repeat (3) @(negedge clk);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_inf",  inf_a,  0);
    chk("reset_x",    xa,     0);
    chk("reset_y",    ya,     0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      launch(0, tbl[i].p, tbl[i].x3, tbl[i].y3, tbl[i].z3);
      wait_done(0, LAT_XY, lat, ok);
      chk($sformatf("vec%0d_done_in_bound", i), ok, 1);
      chk($sformatf("vec%0d_busy_at_done", i), busy_a, 0);
      chk($sformatf("vec%0d_x", i), xa, tbl[i].ex);
      chk($sformatf("vec%0d_y", i), ya, tbl[i].ey);
      chk($sformatf("vec%0d_inf", i), inf_a, tbl[i].einf);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse_one_cycle", i), done_a, 0);
      chk($sformatf("vec%0d_x_held", i), xa, tbl[i].ex);
    end

    // Point at infinity: done exactly two cycles after start
    launch(0, 29, 9, 5, 0);
    wait_done(0, 10, lat, ok);
    chk("zero_done_seen", ok, 1);
    chk("zero_latency", lat, 2);
    chk("zero_inf", inf_a, 1);

    // x-only instance
    launch(1, 29, 9, 5, 27);
    wait_done(1, LAT_X, lat, ok);
    chk("xonly_done_in_bound", ok, 1);
    chk("xonly_x", xb, 24);
    chk("xonly_y", yb, 0);
    chk("xonly_inf", inf_b, 0);

    // start while busy must be ignored
    launch(0, 29, 9, 5, 27);
    repeat (3) @(negedge clk);
    p = 29; x3 = 1; y3 = 1; z3 = 1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, LAT_XY, lat, ok);
    chk("busy_start_done", ok, 1);
    chk("busy_start_x", xa, 24);
    chk("busy_start_y", ya, 3);
    pulses = 0;
    repeat (LAT_XY + 5) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    chk("busy_start_no_second_done", pulses, 0);

    // reset in the middle of the inversion
    launch(0, 251, 100, 200, 123);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_x", xa, 0);
    chk("midrst_y", ya, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (LAT_XY + 5) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    launch(0, 13, 3, 4, 2);
    wait_done(0, LAT_XY, lat, ok);
    chk("midrst_restart_done", ok, 1);
    chk("midrst_restart_x", xa, 4);
    chk("midrst_restart_y", ya, 7);

    // random operands against a brute-force inverse model
    for (int k = 0; k < 30; k++) begin
      rp = primes[$urandom_range(0, 4)];
      rx = $urandom_range(0, rp - 1);
      ry = $urandom_range(0, rp - 1);
      rz = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, rp - 1);
      if (rz == 0) begin
        ex = 0; ey = 0;
      end else begin
        zi = inv_bf(rz, rp);
        ex = (rx * ((zi * zi) % rp)) % rp;
        ey = (ry * ((((zi * zi) % rp) * zi) % rp)) % rp;
      end
      launch(0, W'(rp), W'(rx), W'(ry), W'(rz));
      wait_done(0, LAT_XY, lat, ok);
      chk($sformatf("rnd%0d_done p=%0d z=%0d", k, rp, rz), ok, 1);
      chk($sformatf("rnd%0d_x p=%0d x3=%0d z=%0d", k, rp, rx, rz), xa, ex);
      chk($sformatf("rnd%0d_y p=%0d y3=%0d z=%0d", k, rp, ry, rz), ya, ey);
      chk($sformatf("rnd%0d_inf", k), inf_a, (rz == 0) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
